// File: rtl/lpc_pkg.sv
// Shared LPC definitions used by both the encoder and the decoder.
package lpc_pkg;

    localparam int          LPC_ORDER = 10;
    localparam int          Q_FRAC    = 12;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE,
        EXC,
        MAC,
        OUT
    } lpc_state_t;

endpackage

// File: rtl/lpc_dec_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), right-shifting, seeded on reset.
module lfsr16
    import lpc_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    output logic [15:0] q_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    // Feedback from bit positions 0,2,3,5 enters at the top bit.
    always_comb begin
        fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d = {fb, lfsr_q[15:1]};
    end

    // Advance one step per enable; reload the seed on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
        end else if (en_i) begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q_o = lfsr_q;

endmodule

// File: rtl/lpc_dec.sv
// LPC synthesis filter: impulse/noise excitation into a 10-tap all-pole
// filter, one tap per clock, frame coefficients double-buffered.
//
//   state | meaning
//   IDLE  | waiting for a sample strobe; frame applied on acceptance
//   EXC   | excitation computed, accumulator seeded with e << FRAC
//   MAC   | one tap per clock, k = 1..10
//   OUT   | round, saturate, shift history, pulse vout
module lpc_dec
    import lpc_pkg::*;
#(
    parameter logic signed [15:0] GAIN        = 16'sd8192,
    parameter int                 NOISE_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] A1,
    input  logic signed [15:0] A2,
    input  logic signed [15:0] A3,
    input  logic signed [15:0] A4,
    input  logic signed [15:0] A5,
    input  logic signed [15:0] A6,
    input  logic signed [15:0] A7,
    input  logic signed [15:0] A8,
    input  logic signed [15:0] A9,
    input  logic signed [15:0] A10,
    input  logic               voiced,
    input  logic [15:0]        freq_count,
    input  logic               vin,
    input  logic               v,
    output logic signed [15:0] y,
    output logic               vout,
    output logic               busy,
    output logic               overrun
);

    localparam logic signed [35:0] RND_HALF = 36'sd1 <<< (Q_FRAC - 1);
    localparam logic signed [35:0] SAT_MAX  = 36'sd32767;
    localparam logic signed [35:0] SAT_MIN  = -36'sd32768;
    localparam logic [3:0]         K_LAST   = 4'(LPC_ORDER - 1);

    lpc_state_t state_q, state_d;

    logic signed [15:0] a_in     [LPC_ORDER];
    logic signed [15:0] a_sh_q   [LPC_ORDER];
    logic signed [15:0] a_act_q  [LPC_ORDER];
    logic signed [15:0] hist_q   [LPC_ORDER];
    logic               sh_voiced_q, act_voiced_q;
    logic [15:0]        sh_freq_q, act_freq_q;
    logic               pending_q;
    logic [15:0]        pitch_q, pitch_d;
    logic [3:0]         k_q;
    logic signed [35:0] acc_q;
    logic signed [15:0] y_q;
    logic               vout_q;
    logic               overrun_q;

    logic               accept;
    logic               lfsr_en;
    logic [15:0]        lfsr_w;
    logic signed [15:0] e_c;
    logic signed [31:0] prod;
    logic signed [35:0] rnd;
    logic signed [15:0] y_sat;

    assign a_in = '{A1, A2, A3, A4, A5, A6, A7, A8, A9, A10};

    assign accept = (state_q == IDLE) && v;

    lfsr16 u_lfsr (
        .clk_i (clk),
        .rst_i (rst),
        .en_i  (lfsr_en),
        .q_o   (lfsr_w)
    );

    // Excitation from the active frame; side effects only commit in EXC.
    always_comb begin
        e_c     = '0;
        pitch_d = pitch_q;
        lfsr_en = 1'b0;
        if (act_voiced_q) begin
            if (act_freq_q == 16'd0) begin
                pitch_d = 16'd0;
            end else if (pitch_q == 16'd0) begin
                e_c     = GAIN;
                pitch_d = act_freq_q - 16'd1;
            end else begin
                pitch_d = pitch_q - 16'd1;
            end
        end else begin
            e_c     = $signed(lfsr_w) >>> NOISE_SHIFT;
            lfsr_en = (state_q == EXC);
        end
    end

    // Tap product, rounding and saturation of the accumulated result.
    always_comb begin
        prod = a_act_q[k_q] * hist_q[k_q];
        rnd  = (acc_q + RND_HALF) >>> Q_FRAC;
        if (rnd > SAT_MAX) begin
            y_sat = 16'sh7FFF;
        end else if (rnd < SAT_MIN) begin
            y_sat = -16'sh8000;
        end else begin
            y_sat = rnd[15:0];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (v) state_d = EXC;
            EXC:     state_d = MAC;
            MAC:     if (k_q == K_LAST) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame buffering, excitation state, MAC datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LPC_ORDER; i++) begin
                a_sh_q[i]  <= '0;
                a_act_q[i] <= '0;
                hist_q[i]  <= '0;
            end
            sh_voiced_q  <= 1'b0;
            act_voiced_q <= 1'b0;
            sh_freq_q    <= '0;
            act_freq_q   <= '0;
            pending_q    <= 1'b0;
            pitch_q      <= '0;
            k_q          <= '0;
            acc_q        <= '0;
            y_q          <= '0;
            vout_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            vout_q <= 1'b0;

            if (v && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end

            // Old shadow goes active even when a new frame lands on the same edge.
            if (accept && pending_q) begin
                a_act_q      <= a_sh_q;
                act_voiced_q <= sh_voiced_q;
                act_freq_q   <= sh_freq_q;
            end
            if (vin) begin
                a_sh_q      <= a_in;
                sh_voiced_q <= voiced;
                sh_freq_q   <= freq_count;
                pending_q   <= 1'b1;
            end else if (accept) begin
                pending_q <= 1'b0;
            end

            case (state_q)
                EXC: begin
                    acc_q   <= 36'(e_c) <<< Q_FRAC;
                    pitch_q <= pitch_d;
                    k_q     <= '0;
                end
                MAC: begin
                    acc_q <= acc_q - 36'(prod);
                    k_q   <= k_q + 4'd1;
                end
                OUT: begin
                    y_q       <= y_sat;
                    vout_q    <= 1'b1;
                    hist_q[0] <= y_sat;
                    for (int i = 1; i < LPC_ORDER; i++) begin
                        hist_q[i] <= hist_q[i-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign y       = y_q;
    assign vout    = vout_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_lpc_dec.sv
// Directed bench for lpc_dec: vector table for steady-state sequences,
// hand-written sequences for reset, frame timing, noise and overrun.
module tb_lpc_dec;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] a_tb [10];
    logic               voiced_tb = 1'b0;
    logic [15:0]        freq_tb = '0;
    logic               vin_tb = 1'b0;
    logic               v_tb = 1'b0;
    logic signed [15:0] y_tb;
    logic               vout_tb;
    logic               busy_tb;
    logic               overrun_tb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lpc_dec dut (
        .clk        (clk),
        .rst        (rst),
        .A1         (a_tb[0]),
        .A2         (a_tb[1]),
        .A3         (a_tb[2]),
        .A4         (a_tb[3]),
        .A5         (a_tb[4]),
        .A6         (a_tb[5]),
        .A7         (a_tb[6]),
        .A8         (a_tb[7]),
        .A9         (a_tb[8]),
        .A10        (a_tb[9]),
        .voiced     (voiced_tb),
        .freq_count (freq_tb),
        .vin        (vin_tb),
        .v          (v_tb),
        .y          (y_tb),
        .vout       (vout_tb),
        .busy       (busy_tb),
        .overrun    (overrun_tb)
    );

    typedef struct {
        bit do_rst;
        bit do_load;
        int a1;
        bit vcd;
        int freq;
        int exp_y;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic load_frame(input int a1, input bit vcd, input int freq);
        for (int i = 0; i < 10; i++) a_tb[i] = '0;
        a_tb[0]   = 16'(a1);
        voiced_tb = vcd;
        freq_tb   = 16'(freq);
        vin_tb    = 1'b1;
        tick();
        vin_tb    = 1'b0;
    endtask

    // Ticks until vout is seen; returns the tick count, or -1 on timeout.
    task automatic wait_vout(output int n);
        n = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (vout_tb) begin
                n = i;
                break;
            end
        end
    endtask

    // Strobe v once (edge 0) and return the number of edges until vout.
    task automatic run_sample(output int lat);
        v_tb = 1'b1;
        tick();
        v_tb = 1'b0;
        chk("busy_after_accept", int'(busy_tb), 1);
        wait_vout(lat);
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    initial begin
        int lat;
        int cnt;
        logic [15:0] l1, l2;
        int e1, e2, exp1, exp2;

        for (int i = 0; i < 10; i++) a_tb[i] = '0;

        // decay: y = e + 0.5*y[n-1]
        vecs[0]  = '{1, 1, -2048, 1, 100, 8192};
        vecs[1]  = '{0, 0, 0, 0, 0, 4096};
        vecs[2]  = '{0, 0, 0, 0, 0, 2048};
        vecs[3]  = '{0, 0, 0, 0, 0, 1024};
        vecs[4]  = '{0, 0, 0, 0, 0, 512};
        // pitch train, period 4
        vecs[5]  = '{1, 1, 0, 1, 4, 8192};
        vecs[6]  = '{0, 0, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 0, 0, 0, 0};
        vecs[8]  = '{0, 0, 0, 0, 0, 0};
        vecs[9]  = '{0, 0, 0, 0, 0, 8192};
        vecs[10] = '{0, 0, 0, 0, 0, 0};
        // saturation: y = e + 2*y[n-1]
        vecs[11] = '{1, 1, -8192, 1, 100, 8192};
        vecs[12] = '{0, 0, 0, 0, 0, 16384};
        vecs[13] = '{0, 0, 0, 0, 0, 32767};
        vecs[14] = '{0, 0, 0, 0, 0, 32767};

        // Reset values, with v held high through reset.
        rst  = 1'b1;
        v_tb = 1'b1;
        repeat (3) tick();
        chk("rst_y", int'(y_tb), 0);
        chk("rst_vout", int'(vout_tb), 0);
        chk("rst_busy", int'(busy_tb), 0);
        chk("rst_overrun", int'(overrun_tb), 0);
        rst  = 1'b0;
        v_tb = 1'b0;
        cnt  = 0;
        repeat (16) begin
            tick();
            if (vout_tb) cnt++;
        end
        chk("v_during_rst_vouts", cnt, 0);

        // Vector table.
        for (int i = 0; i < 15; i++) begin
            if (vecs[i].do_rst) do_reset();
            if (vecs[i].do_load) load_frame(vecs[i].a1, vecs[i].vcd, vecs[i].freq);
            run_sample(lat);
            chk($sformatf("vec%0d_latency", i), lat, 12);
            chk($sformatf("vec%0d_y", i), int'(y_tb), vecs[i].exp_y);
            tick();
            chk($sformatf("vec%0d_vout_one_cycle", i), int'(vout_tb), 0);
            chk($sformatf("vec%0d_busy_idle", i), int'(busy_tb), 0);
            repeat (6) tick();
        end

        // Reset mid-computation abandons the sample.
        load_frame(0, 1, 4);
        v_tb = 1'b1;
        tick();
        v_tb = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_busy", int'(busy_tb), 0);
        cnt = 0;
        repeat (16) begin
            tick();
            if (vout_tb) cnt++;
        end
        chk("midrst_vouts", cnt, 0);

        // Unvoiced noise and a frame change arriving mid-sample.
        do_reset();
        l1   = 16'hACE1;
        l2   = lfsr_step(l1);
        e1   = int'($signed(l1)) >>> 3;
        e2   = int'($signed(l2)) >>> 3;
        exp1 = e1;
        exp2 = (e2 * 4096 + 2048 * exp1 + 2048) >>> 12;
        load_frame(0, 0, 0);
        v_tb = 1'b1;
        tick();
        v_tb = 1'b0;
        repeat (4) tick();
        load_frame(-2048, 0, 0);
        wait_vout(lat);
        chk("uv1_latency_rest", lat, 7);
        chk("uv1_y", int'(y_tb), exp1);
        chk("uv1_y_hand", int'(y_tb), -2660);
        repeat (5) tick();
        run_sample(lat);
        chk("uv2_latency", lat, 12);
        chk("uv2_y", int'(y_tb), exp2);
        chk("uv2_y_hand", int'(y_tb), 1436);

        // Overrun: v at edges 0 and 6, then 13.
        do_reset();
        load_frame(0, 1, 4);
        v_tb = 1'b1;
        tick();
        v_tb = 1'b0;
        cnt  = 0;
        lat  = -1;
        for (int e = 1; e <= 12; e++) begin
            v_tb = (e == 6);
            tick();
            v_tb = 1'b0;
            if (vout_tb) begin
                cnt++;
                lat = e;
            end
        end
        chk("ovr_vout_count", cnt, 1);
        chk("ovr_vout_edge", lat, 12);
        chk("ovr_flag", int'(overrun_tb), 1);
        chk("ovr_y", int'(y_tb), 8192);
        run_sample(lat);
        chk("ovr_edge13_latency", lat, 12);
        chk("ovr_edge13_y", int'(y_tb), 0);
        chk("ovr_sticky", int'(overrun_tb), 1);
        do_reset();
        chk("ovr_cleared_by_rst", int'(overrun_tb), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
